// File: rtl/gray_to_binary_sync.sv
// Gray-coded count synchroniser: two-flop capture, registered Gray-to-binary decode,
// and per-update strobes for step direction and Gray-rule violations.
module gray_to_binary_sync #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] g_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] b_out,
  output logic             b_valid,
  output logic             step_up,
  output logic             step_dn,
  output logic             err,
  output logic             err_sticky
);

  logic [WIDTH-1:0] g_s1_q, g_s2_q, g_prev_q;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] bin_c, diff_c;
  logic             chg_c, multi_c;
  logic             valid_q, valid_d;
  logic             up_q, up_d;
  logic             dn_q, dn_d;
  logic             err_q, err_d;
  logic             sticky_q, sticky_d;
  logic             first_q, first_d;

  // Plain two-flop synchroniser; nothing may sit between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_s1_q <= '0;
      g_s2_q <= '0;
    end else begin
      g_s1_q <= g_in;
      g_s2_q <= g_s1_q;
    end
  end

  // Binary bit i is the XOR of all Gray bits at or above i.
  always_comb begin
    bin_c = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      bin_c[i] = ^(g_s2_q >> i);
    end
  end

  always_comb begin
    chg_c    = (g_s2_q != g_prev_q);
    diff_c   = g_s2_q ^ g_prev_q;
    multi_c  = |(diff_c & (diff_c - WIDTH'(1)));
    b_d      = bin_c;
    valid_d  = chg_c;
    up_d     = chg_c & ~first_q & (bin_c == b_q + WIDTH'(1));
    dn_d     = chg_c & ~first_q & (bin_c == b_q - WIDTH'(1));
    err_d    = chg_c & ~first_q & multi_c;
    sticky_d = err_d | (sticky_q & ~clr_err);
    first_d  = first_q & ~chg_c;
  end

  // first starts set so the unknown pre-reset upstream value never yields a step or error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      g_prev_q <= '0;
      b_q      <= '0;
      valid_q  <= 1'b0;
      up_q     <= 1'b0;
      dn_q     <= 1'b0;
      err_q    <= 1'b0;
      sticky_q <= 1'b0;
      first_q  <= 1'b1;
    end else begin
      g_prev_q <= g_s2_q;
      b_q      <= b_d;
      valid_q  <= valid_d;
      up_q     <= up_d;
      dn_q     <= dn_d;
      err_q    <= err_d;
      sticky_q <= sticky_d;
      first_q  <= first_d;
    end
  end

  assign b_out      = b_q;
  assign b_valid    = valid_q;
  assign step_up    = up_q;
  assign step_dn    = dn_q;
  assign err        = err_q;
  assign err_sticky = sticky_q;

endmodule

// File: tb/tb_gray_to_binary_sync.sv
// Bench for gray_to_binary_sync: directed test-plan steps followed by a randomized walk,
// all checked against a sample-history reference model.
module tb_gray_to_binary_sync;

  localparam int W = 4;
  localparam int M = 1 << W;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] g_in = '0;
  logic         clr_err = 1'b0;
  logic [W-1:0] b_out;
  logic         b_valid, step_up, step_dn, err, err_sticky;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state
  int   pipe[$];
  int   m_prev;
  bit   m_first;
  int   e_b;
  bit   e_v, e_up, e_dn, e_err, e_sticky;

  gray_to_binary_sync #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .g_in(g_in), .clr_err(clr_err),
    .b_out(b_out), .b_valid(b_valid), .step_up(step_up), .step_dn(step_dn),
    .err(err), .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  // Gray decode by search: the binary b whose reflected code b^(b>>1) equals g.
  function automatic int g2b(input int g);
    for (int b = 0; b < M; b++) begin
      if ((b ^ (b >> 1)) == g) return b;
    end
    return -1;
  endfunction

  function automatic logic [W-1:0] b2g(input int b);
    return W'(b ^ (b >> 1));
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    pipe = '{0, 0};
    m_prev = 0; m_first = 1'b1;
    e_b = 0; e_v = 0; e_up = 0; e_dn = 0; e_err = 0; e_sticky = 0;
  endtask

  // Value accepted at an edge is the g_in sampled two edges earlier.
  task automatic model_edge();
    int acc, nb;
    bit chg;
    if (rst) begin
      model_reset();
      return;
    end
    acc = pipe.pop_front();
    pipe.push_back(int'(g_in));
    chg = (acc != m_prev);
    nb = g2b(acc);
    e_v   = chg;
    e_up  = chg && !m_first && (nb == (e_b + 1) % M);
    e_dn  = chg && !m_first && (nb == (e_b + M - 1) % M);
    e_err = chg && !m_first && ($countones(acc ^ m_prev) > 1);
    e_sticky = e_err || (e_sticky && !clr_err);
    e_b = nb;
    m_first = m_first && !chg;
    m_prev = acc;
  endtask

  task automatic check_all();
    check("b_out", 32'(b_out), 32'(e_b));
    check("b_valid", 32'(b_valid), 32'(e_v));
    check("step_up", 32'(step_up), 32'(e_up));
    check("step_dn", 32'(step_dn), 32'(e_dn));
    check("err", 32'(err), 32'(e_err));
    check("err_sticky", 32'(err_sticky), 32'(e_sticky));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous reset from between edges, held for two edges.
  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    #1;
    check_all();
    check("async_rst_b_out", 32'(b_out), 32'd0);
    ticks(2);
    rst = 1'b0;
  endtask

  initial begin
    int cb, nb, r, hold;
    #2;
    do_reset();

    // Idle at zero: no strobes
    ticks(10);
    check("idle_b_out", 32'(b_out), 32'd0);
    check("idle_sticky", 32'(err_sticky), 32'd0);

    // First change suppressed, second gives step_up
    g_in = 4'b0001;
    ticks(3);
    check("first_b_out", 32'(b_out), 32'd1);
    check("first_valid", 32'(b_valid), 32'd1);
    check("first_up", 32'(step_up), 32'd0);
    ticks(2);
    g_in = 4'b0011;
    ticks(3);
    check("second_b_out", 32'(b_out), 32'd2);
    check("second_up", 32'(step_up), 32'd1);
    check("second_err", 32'(err), 32'd0);

    // Full cycle up then down through both wraps, one change per 4 cycles
    for (int k = 1; k <= M; k++) begin
      g_in = b2g((2 + k) % M);
      ticks(4);
    end
    for (int k = 1; k <= M; k++) begin
      g_in = b2g((2 + M - k) % M);
      ticks(4);
    end
    check("walk_b_out", 32'(b_out), 32'd2);
    check("walk_sticky", 32'(err_sticky), 32'd0);

    // Explicit wrap 15 -> 0 is a step_up
    g_in = 4'b1000;
    ticks(4);
    g_in = 4'b0000;
    ticks(3);
    check("wrap_b_out", 32'(b_out), 32'd0);
    check("wrap_up", 32'(step_up), 32'd1);
    g_in = 4'b0001;
    ticks(4);
    g_in = 4'b0011;
    ticks(4);

    // Multi-bit change from gray 0011 to 0000
    g_in = 4'b0000;
    ticks(3);
    check("multi_b_out", 32'(b_out), 32'd0);
    check("multi_err", 32'(err), 32'd1);
    check("multi_up", 32'(step_up), 32'd0);
    check("multi_dn", 32'(step_dn), 32'd0);
    ticks(3);
    check("sticky_held", 32'(err_sticky), 32'd1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("sticky_cleared", 32'(err_sticky), 32'd0);

    // Clear coinciding with a new error: set wins
    g_in = 4'b0110;
    ticks(2);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    check("coincide_err", 32'(err), 32'd1);
    check("coincide_sticky", 32'(err_sticky), 32'd1);
    ticks(2);

    // Reach b_out=5, then reset mid-operation
    g_in = 4'b0111;
    ticks(4);
    check("pre_rst_b_out", 32'(b_out), 32'd5);
    do_reset();
    ticks(3);
    check("post_rst_b_out", 32'(b_out), 32'd5);
    check("post_rst_valid", 32'(b_valid), 32'd1);
    check("post_rst_up", 32'(step_up), 32'd0);
    check("post_rst_err", 32'(err), 32'd0);

    // Randomized walk: mostly unit steps, some jumps, random clears and resets
    for (int k = 0; k < 200; k++) begin
      cb = g2b(int'(g_in));
      r = int'($urandom_range(0, 9));
      if (r < 5)      nb = (cb + 1) % M;
      else if (r < 8) nb = (cb + M - 1) % M;
      else            nb = int'($urandom_range(0, M - 1));
      g_in = b2g(nb);
      clr_err = ($urandom_range(0, 5) == 0);
      hold = int'($urandom_range(1, 4));
      for (int h = 0; h < hold; h++) begin
        tick();
        clr_err = 1'b0;
      end
      if ($urandom_range(0, 39) == 0) do_reset();
    end
    ticks(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gray_to_binary_sync.md
Name: gray_to_binary_sync

Overview:
- Receives a Gray-coded count (e.g. a pointer or position encoder value) launched asynchronously to the local clock.
- Synchronises it through a two-flop stage, then decodes it to binary in a registered stage.
- Flags each update with a one-cycle strobe, the step direction and a Gray-rule violation.
- Local-domain counterpart of the binary-to-Gray encoder used on the launching side.

Parameters:
- WIDTH, 4, bit width of the Gray input and the binary output (minimum 2).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- g_in  input  WIDTH  Gray-coded value, asynchronous to clk.
- clr_err  input  1  synchronous clear for err_sticky.
- b_out  output  WIDTH  decoded binary value, registered.
- b_valid  output  1  one-cycle pulse when b_out takes a new value.
- step_up  output  1  one-cycle pulse, new binary value = previous + 1 (mod 2^WIDTH).
- step_dn  output  1  one-cycle pulse, new binary value = previous - 1 (mod 2^WIDTH).
- err  output  1  one-cycle pulse, more than one Gray bit changed between accepted samples.
- err_sticky  output  1  latched OR of err.

Behaviour:
- Reset: clk and rst are the single clock and reset; rst is asynchronous and active-high.
  - While rst=1, all registers are 0: g_s1, g_s2, g_prev, b_out, b_valid, step_up, step_dn, err, err_sticky.
  - While rst=1, the first flag is 1.
  - Release is synchronous to clk.
- Sync stage: each edge, g_s1 <= g_in and g_s2 <= g_s1. No logic sits between the two flops.
- Decode: bin(g) has MSB = g[W-1]; each lower bit bin[i] = bin[i+1] XOR g[i]. The decode is combinational on g_s2 and feeds only registers.
- Change detect: chg = (g_s2 != g_prev) and diff = g_s2 XOR g_prev.
- Each edge, when not in reset:
  - g_prev <= g_s2.
  - b_out <= bin(g_s2). Registered every cycle; value only changes when chg=1.
  - b_valid <= chg.
  - step_up <= chg & !first & (bin(g_s2) == b_out + 1 mod 2^W).
  - step_dn <= chg & !first & (bin(g_s2) == b_out - 1 mod 2^W).
  - err <= chg & !first & (popcount(diff) > 1).
  - first <= first & !chg.
- err_sticky:
  - Sets on any cycle where err is asserted next.
  - clr_err=1 clears it.
  - When set and clear coincide, set wins.
- Latency: a stable g_in change meeting setup before edge N appears on b_out, together with its strobes, after edge N+2 (3 edges).
- A single-bit change produces exactly one b_valid pulse and exactly one of step_up/step_dn.
- Wrap-around: gray 1000 -> 0000 (W=4) decodes 15 -> 0, giving step_up. The reverse direction gives step_dn. Wrap is never an error.
- First change after reset:
  - b_valid=1.
  - step_up, step_dn and err are suppressed, because the upstream value at reset is unknown.
  - first then clears.
- Multi-bit change:
  - b_out still updates to bin(g_s2).
  - b_valid=1, err=1, and step_up and step_dn are both 0.
  - Error is reported, not corrected.
- Held input: no strobes while g_s2 is unchanged; b_out holds.
- Reset mid-operation clears all state immediately. After release, behaviour is as from power-up, including first=1.
- step_up and step_dn are mutually exclusive for WIDTH>=2.
- err is never asserted together with step_up or step_dn.

Test Plan:
- Reset then g_in=0000 held 10 cycles -> b_out=0000, no b_valid/step/err pulses, err_sticky=0.
- After reset g_in 0000->0001, then 5 cycles later 0001->0011 ->
  - b_out=0001 at the 3rd edge with b_valid=1, step_up=0 (first);
  - then b_out=0010 with b_valid=1, step_up=1, err=0.
- Walk g_in through the full 16-value Gray up sequence and back down, one change per 4 cycles ->
  - b_out follows 0..15 then 15..0;
  - step_up on each up change, step_dn on each down change, including the 15->0 and 0->15 wraps;
  - err never asserted.
- From b_out=0010 (gray 0011) drive g_in=0000 -> b_out=0000, b_valid=1, err=1, step_up=step_dn=0, err_sticky=1 and held. Then pulse clr_err -> err_sticky=0.
- clr_err asserted in the same cycle as a new err (gray 0000->0110) -> err_sticky remains 1.
- Assert rst mid-sequence (b_out=0101) -> all outputs 0 asynchronously. After release with g_in=0111 steady -> b_out=0101 with b_valid=1, no step/err (first change suppressed).
